// File: rtl/wb_arb_pkg.sv
// Shared widths, payload type and source encoding for the writeback port arbiter.
package wb_arb_pkg;
   localparam int unsigned WB_DATA_W = 64;
   localparam int unsigned WB_RD_W   = 5;
   localparam int unsigned WB_PPP_W  = 8;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [WB_RD_W-1:0]   rd;
      logic [WB_PPP_W-1:0]  ppp;
   } wb_entry_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LD  = 1'b1
   } wb_src_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// EX offer, load return and register-file write bundle for wb_port_arbiter.
interface wb_port_arbiter_if;
   import wb_arb_pkg::*;

   logic                 ex_valid;
   logic [WB_DATA_W-1:0] ex_data;
   logic [WB_RD_W-1:0]   ex_rd;
   logic [WB_PPP_W-1:0]  ex_ppp;
   logic                 ex_stall;
   logic                 ld_valid;
   logic [WB_DATA_W-1:0] ld_data;
   logic [WB_RD_W-1:0]   ld_rd;
   logic [WB_PPP_W-1:0]  ld_ppp;
   logic                 wb_we;
   logic [WB_DATA_W-1:0] wb_data;
   logic [WB_RD_W-1:0]   wb_rd;
   logic [WB_PPP_W-1:0]  wb_ppp;
   logic                 wb_src;

   modport master (
      output ex_valid, ex_data, ex_rd, ex_ppp, ld_valid, ld_data, ld_rd, ld_ppp,
      input  ex_stall, wb_we, wb_data, wb_rd, wb_ppp, wb_src
   );

   modport slave (
      input  ex_valid, ex_data, ex_rd, ex_ppp, ld_valid, ld_data, ld_rd, ld_ppp,
      output ex_stall, wb_we, wb_data, wb_rd, wb_ppp, wb_src
   );
endinterface

// File: rtl/wb_skid_fifo.sv
// Power-of-two holding queue for ALU results waiting on the writeback port.
module wb_skid_fifo
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_entry_t                push_data,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   wb_entry_t       mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between load returns and ALU results.
// Define WB_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_STALL_CNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t     ex_e;
   wb_entry_t     ld_e;
   wb_entry_t     head_e;
   wb_entry_t     sel_e;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          accept;
   logic          sel_ld;
   logic          sel_fifo;
   logic          sel_ex;
   logic          push;
   logic          pop;

   assign ex_e = '{data: bus.ex_data, rd: bus.ex_rd, ppp: bus.ex_ppp};
   assign ld_e = '{data: bus.ld_data, rd: bus.ld_rd, ppp: bus.ld_ppp};

   // Stall depends only on the registered occupancy, never on this cycle's inputs.
   assign bus.ex_stall = (count == CW'(FIFO_DEPTH));

   always_comb begin
      sel_ld   = bus.ld_valid;
      sel_fifo = ~bus.ld_valid & ~empty;
      accept   = bus.ex_valid & ~full & (|bus.ex_ppp);
      sel_ex   = ~bus.ld_valid & empty & accept;
      push     = accept & ~sel_ex;
      pop      = sel_fifo;
      sel_e    = ex_e;
      if (sel_ld)        sel_e = ld_e;
      else if (sel_fifo) sel_e = head_e;
   end

   wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (ex_e),
      .pop       (pop),
      .head      (head_e),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.wb_we   <= 1'b0;
         bus.wb_data <= '0;
         bus.wb_rd   <= '0;
         bus.wb_ppp  <= '0;
         bus.wb_src  <= SRC_ALU;
      end else begin
         bus.wb_we  <= sel_ld | sel_fifo | sel_ex;
         bus.wb_src <= sel_ld ? SRC_LD : SRC_ALU;
         if (sel_ld | sel_fifo | sel_ex)
            {bus.wb_data, bus.wb_rd, bus.wb_ppp} <= sel_e;
      end
   end

`ifdef WB_ARB_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst)
         stall_cnt <= '0;
      else if (bus.ex_stall && bus.ex_valid && stall_cnt != '1)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts each write.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic      we;
      wb_entry_t e;
      logic      src;
      logic      stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_port_arbiter_if bus ();
`ifdef WB_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   wb_port_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef WB_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   exp_t      exp_q[$];
   wb_entry_t alu_q[$];
   wb_entry_t last_e;
   logic [15:0] cnt_m;
   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic wb_entry_t ent(input logic [63:0] d, input logic [4:0] r, input logic [7:0] p);
      wb_entry_t e;
      e.data = d;
      e.rd   = r;
      e.ppp  = p;
      return e;
   endfunction

   // Drive one cycle, predict the result, then compare #1 after the edge.
   task automatic cycle(input logic rstv, input logic ldv, input wb_entry_t ld,
                        input logic exv, input wb_entry_t ex, output logic taken);
      exp_t x;
      logic acc;
      rst          = rstv;
      bus.ld_valid = ldv;
      bus.ld_data  = ld.data;
      bus.ld_rd    = ld.rd;
      bus.ld_ppp   = ld.ppp;
      bus.ex_valid = exv;
      bus.ex_data  = ex.data;
      bus.ex_rd    = ex.rd;
      bus.ex_ppp   = ex.ppp;
      taken = 1'b0;
      x.we = 1'b0; x.e = '0; x.src = 1'b0; x.stall = 1'b0;
      if (!rstv) begin
         alu_q.delete();
         last_e = '0;
         cnt_m  = '0;
      end else begin
         taken = exv && (alu_q.size() < DEPTH);
         acc   = taken && (ex.ppp != 8'h00);
         if (exv && alu_q.size() == DEPTH && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
         x.we = 1'b1;
         if (ldv) begin
            x.e = ld; x.src = 1'b1;
         end else if (alu_q.size() > 0) begin
            x.e = alu_q.pop_front();
         end else if (acc) begin
            x.e = ex; acc = 1'b0;
         end else begin
            x.we = 1'b0; x.e = last_e;
         end
         if (acc) alu_q.push_back(ex);
         last_e  = x.e;
         x.stall = (alu_q.size() == DEPTH);
      end
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check_val("wb_we",    64'(bus.wb_we),    64'(x.we));
      check_val("wb_data",  bus.wb_data,       x.e.data);
      check_val("wb_rd",    64'(bus.wb_rd),    64'(x.e.rd));
      check_val("wb_ppp",   64'(bus.wb_ppp),   64'(x.e.ppp));
      check_val("wb_src",   64'(bus.wb_src),   64'(x.src));
      check_val("ex_stall", 64'(bus.ex_stall), 64'(x.stall));
`ifdef WB_ARB_STALL_CNT_EN
      check_val("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
`endif
   endtask

   initial begin
      wb_entry_t z;
      wb_entry_t off;
      logic t;
      logic have;
      int k;
      int alu_wr[$];
      z = '0;
      rst = 1'b0;
      bus.ex_valid = 1'b0; bus.ld_valid = 1'b0;
      @(negedge clk);

      cycle(1'b0, 1'b1, ent(64'h55, 5'd9, 8'hFF), 1'b1, ent(64'h66, 5'd4, 8'hFF), t);
      check_val("reset_we", 64'(bus.wb_we), 64'd0);
      check_val("reset_stall", 64'(bus.ex_stall), 64'd0);

      // Lone ALU offer bypasses straight to the port.
      cycle(1'b1, 1'b0, z, 1'b1, ent(64'h1122, 5'd3, 8'hFF), t);
      check_val("lone_we", 64'(bus.wb_we), 64'd1);
      check_val("lone_rd", 64'(bus.wb_rd), 64'd3);
      check_val("lone_data", bus.wb_data, 64'h1122);
      check_val("lone_src", 64'(bus.wb_src), 64'd0);
      cycle(1'b1, 1'b0, z, 1'b0, z, t);
      check_val("idle_we", 64'(bus.wb_we), 64'd0);
      check_val("idle_hold_rd", 64'(bus.wb_rd), 64'd3);

      // Load beats a same-cycle ALU offer; the ALU result follows.
      cycle(1'b1, 1'b1, ent(64'hAA, 5'd5, 8'hFF), 1'b1, ent(64'hBB, 5'd6, 8'hFF), t);
      check_val("coll_ld_rd", 64'(bus.wb_rd), 64'd5);
      check_val("coll_ld_src", 64'(bus.wb_src), 64'd1);
      cycle(1'b1, 1'b0, z, 1'b0, z, t);
      check_val("coll_ex_rd", 64'(bus.wb_rd), 64'd6);
      check_val("coll_ex_src", 64'(bus.wb_src), 64'd0);

      // Load with no byte lanes still writes; ALU offer with no lanes is dropped.
      cycle(1'b1, 1'b1, ent(64'h77, 5'd8, 8'h00), 1'b1, ent(64'h88, 5'd9, 8'h00), t);
      check_val("ld_ppp0_we", 64'(bus.wb_we), 64'd1);
      check_val("ld_ppp0_ppp", 64'(bus.wb_ppp), 64'd0);
      cycle(1'b1, 1'b0, z, 1'b0, z, t);
      check_val("ex_ppp0_dropped", 64'(bus.wb_we), 64'd0);

      // Loads for 4 cycles with offers rd=1,2,3 held until consumed.
      k = 0;
      alu_wr.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, ent(64'h100 + 64'(i), 5'(20 + i), 8'hFF), k < 3,
               ent(64'h200 + 64'(k), 5'(k + 1), 8'hFF), t);
         if (t) k++;
         if (i == 1) check_val("fill_stall", 64'(bus.ex_stall), 64'd1);
      end
      check_val("fill_accepted", 64'(k), 64'd2);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, z, k < 3, ent(64'h200 + 64'(k), 5'(k + 1), 8'hFF), t);
         if (t) k++;
         if (bus.wb_we && !bus.wb_src) alu_wr.push_back(int'(bus.wb_rd));
      end
      check_val("order_cnt", 64'(alu_wr.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < alu_wr.size()) check_val("order_rd", 64'(alu_wr[i]), 64'(i + 1));
      end

      // Reset with two entries queued discards them.
      cycle(1'b1, 1'b1, ent(64'h300, 5'd30, 8'hFF), 1'b1, ent(64'h307, 5'd7, 8'hFF), t);
      cycle(1'b1, 1'b1, ent(64'h301, 5'd31, 8'hFF), 1'b1, ent(64'h308, 5'd8, 8'hFF), t);
      check_val("pre_rst_stall", 64'(bus.ex_stall), 64'd1);
      cycle(1'b0, 1'b1, ent(64'h302, 5'd29, 8'hFF), 1'b1, ent(64'h309, 5'd9, 8'hFF), t);
      check_val("mid_rst_we", 64'(bus.wb_we), 64'd0);
      check_val("mid_rst_stall", 64'(bus.ex_stall), 64'd0);
      alu_wr.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, z, 1'b0, z, t);
         if (bus.wb_we) alu_wr.push_back(int'(bus.wb_rd));
      end
      check_val("discarded_writes", 64'(alu_wr.size()), 64'd0);

`ifdef WB_ARB_STALL_CNT_EN
      cycle(1'b0, 1'b0, z, 1'b0, z, t);
      cycle(1'b1, 1'b1, ent(64'h1, 5'd1, 8'hFF), 1'b1, ent(64'h2, 5'd2, 8'hFF), t);
      cycle(1'b1, 1'b1, ent(64'h1, 5'd1, 8'hFF), 1'b1, ent(64'h3, 5'd3, 8'hFF), t);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 1'b1, ent(64'h1, 5'd1, 8'hFF), 1'b1, ent(64'h4, 5'd4, 8'hFF), t);
      check_val("stall_cnt_10", 64'(stall_cnt), 64'd10);
`endif

      // Random traffic; an ALU offer stays on the bus until the model says it was taken.
      have = 1'b0;
      off  = '0;
      for (int i = 0; i < 400; i++) begin
         if (!have && ($urandom_range(1) == 1)) begin
            off  = ent({$urandom, $urandom}, 5'($urandom_range(31)),
                       ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            have = 1'b1;
         end
         cycle(($urandom_range(49) != 0), ($urandom_range(2) == 0),
               ent({$urandom, $urandom}, 5'($urandom_range(31)), 8'($urandom_range(255))),
               have, off, t);
         if (t || !rst) have = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
